// File: rtl/acc_seq_pkg.sv
// -----------------------------------------------------------------------------
// acc_seq_pkg
//
// Purpose : Shared definitions for the accumulator sequencer: instruction
//           opcodes, ALU operation codes, the controller state encoding and
//           the instruction classes produced by the opcode decoder.
//
// Ports   : none (package).
// -----------------------------------------------------------------------------
package acc_seq_pkg;

    // Opcodes, carried in ir[7:4]. Values 4'hA..4'hE are unassigned and
    // execute as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_STA = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_AND = 4'h5;
    localparam logic [3:0] OP_OR  = 4'h6;
    localparam logic [3:0] OP_XOR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    // ALU operation codes. For the arithmetic/logic opcodes the code equals
    // opcode - 3.
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;

    // Controller states. Explicit encodings keep the register values stable
    // for anyone probing them on a board or in a waveform.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_MEM    = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    // What the controller has to do with an instruction once it is decoded.
    typedef enum logic [2:0] {
        CLS_NOP = 3'd0,   // NOP and unassigned opcodes
        CLS_LDA = 3'd1,   // load accumulator from memory
        CLS_STA = 3'd2,   // store accumulator to memory
        CLS_ALU = 3'd3,   // ADD..XOR: accumulator op memory operand
        CLS_JMP = 3'd4,   // unconditional jump
        CLS_JZ  = 3'd5,   // jump when accumulator is zero
        CLS_HLT = 3'd6    // stop until reset
    } op_class_t;

    // Program counter increment; the 4-bit result wraps 15 -> 0 by itself.
    function automatic logic [3:0] pc_inc(input logic [3:0] pc_cur);
        return pc_cur + 4'd1;
    endfunction

endpackage

// File: rtl/acc_seq_decode.sv
// -----------------------------------------------------------------------------
// acc_seq_decode
//
// Purpose : Purely combinational opcode decoder. Maps the instruction opcode
//           to the controller's instruction class plus the ALU operation and
//           accumulator source select that apply during the memory cycle.
//
// Ports   : opcode   in  [3:0]  instruction opcode (ir[7:4])
//           op_class out        instruction class (op_class_t)
//           alu_op   out [2:0]  ALU operation for ADD..XOR, ALU_ADD otherwise
//           acc_sel  out        1 = accumulator loads the ALU result,
//                               0 = accumulator loads the bus
// -----------------------------------------------------------------------------
module acc_seq_decode
    import acc_seq_pkg::*;
(
    input  logic [3:0] opcode,
    output op_class_t  op_class,
    output logic [2:0] alu_op,
    output logic       acc_sel
);

    always_comb begin
        // NOTE: every output gets a default before the case so that no path
        // through the block leaves one unassigned, which would infer a latch.
        op_class = CLS_NOP;
        alu_op   = ALU_ADD;
        acc_sel  = 1'b0;

        case (opcode)
            OP_LDA: op_class = CLS_LDA;
            OP_STA: op_class = CLS_STA;
            OP_ADD: begin
                op_class = CLS_ALU;
                alu_op   = ALU_ADD;
                acc_sel  = 1'b1;
            end
            OP_SUB: begin
                op_class = CLS_ALU;
                alu_op   = ALU_SUB;
                acc_sel  = 1'b1;
            end
            OP_AND: begin
                op_class = CLS_ALU;
                alu_op   = ALU_AND;
                acc_sel  = 1'b1;
            end
            OP_OR: begin
                op_class = CLS_ALU;
                alu_op   = ALU_OR;
                acc_sel  = 1'b1;
            end
            OP_XOR: begin
                op_class = CLS_ALU;
                alu_op   = ALU_XOR;
                acc_sel  = 1'b1;
            end
            OP_JMP: op_class = CLS_JMP;
            OP_JZ:  op_class = CLS_JZ;
            OP_HLT: op_class = CLS_HLT;
            default: op_class = CLS_NOP;   // NOP and 4'hA..4'hE
        endcase
    end

endmodule

// File: rtl/acc_sequencer.sv
// -----------------------------------------------------------------------------
// acc_sequencer
//
// Purpose : Control sequencer for a small accumulator machine. Fetches 8-bit
//           instructions (opcode in [7:4], operand/address in [3:0]) from a
//           16-entry memory, decodes them and steers the accumulator, the ALU
//           and the memory handshake. Memory accesses use a req/ack handshake
//           with an unbounded number of wait states.
//
// Build option:
//           ACC_SEQ_STEP_EN  - when defined, adds the 'step' input. The
//                              sequencer waits in IDLE until step=1 and
//                              returns to IDLE after every completed
//                              instruction (single-step mode). When undefined
//                              the port does not exist and the sequencer runs
//                              freely from IDLE into FETCH.
//
// Ports   : clk           in        rising-edge clock
//           rst           in        asynchronous active-high reset
//           step          in        single-step request (ACC_SEQ_STEP_EN only)
//           mem_req       out       memory request, held until mem_ack
//           mem_we        out       1 = write (STA), 0 = read
//           mem_addr      out [3:0] memory address
//           mem_ack       in        one-cycle completion strobe; read data is
//                                   on bus_in in that cycle
//           bus_in        in  [7:0] shared data bus (instruction / operand)
//           acc_value     in  [7:0] accumulator contents (JZ zero test)
//           acc_sel       out       accumulator source: 1 = ALU, 0 = bus
//           acc_write_en  out       accumulator load strobe
//           acc_output_en out       accumulator drives the bus (STA)
//           alu_op        out [2:0] ALU operation
//           pc            out [3:0] program counter
//           halted        out       high while in HALT
// -----------------------------------------------------------------------------
module acc_sequencer
    import acc_seq_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
`ifdef ACC_SEQ_STEP_EN
    input  logic       step,
`endif
    output logic       mem_req,
    output logic       mem_we,
    output logic [3:0] mem_addr,
    input  logic       mem_ack,
    input  logic [7:0] bus_in,
    input  logic [7:0] acc_value,
    output logic       acc_sel,
    output logic       acc_write_en,
    output logic       acc_output_en,
    output logic [2:0] alu_op,
    output logic [3:0] pc,
    output logic       halted
);

    // -------------------------------------------------------------------------
    // Build-time behaviour of the optional single-step mode.
    // idle_go    : condition for leaving IDLE.
    // DONE_STATE : where the controller goes once an instruction completes.
    // -------------------------------------------------------------------------
    logic idle_go;

`ifdef ACC_SEQ_STEP_EN
    localparam state_t DONE_STATE = ST_IDLE;
    assign idle_go = step;
`else
    localparam state_t DONE_STATE = ST_FETCH;
    assign idle_go = 1'b1;
`endif

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_t     state, state_d;
    logic [3:0] pc_d;
    logic [7:0] ir, ir_d;

    logic [3:0] opcode;
    logic [3:0] operand;

    assign opcode  = ir[7:4];
    assign operand = ir[3:0];

    // -------------------------------------------------------------------------
    // Opcode decode
    // -------------------------------------------------------------------------
    op_class_t  dec_class;
    logic [2:0] dec_alu_op;
    logic       dec_acc_sel;

    acc_seq_decode u_decode (
        .opcode   (opcode),
        .op_class (dec_class),
        .alu_op   (dec_alu_op),
        .acc_sel  (dec_acc_sel)
    );

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state;
        pc_d    = pc;
        ir_d    = ir;

        case (state)
            ST_IDLE: begin
                if (idle_go) begin
                    state_d = ST_FETCH;
                end
            end

            ST_FETCH: begin
                // The instruction byte is only valid on the bus in the ack
                // cycle, so capture and advance together.
                if (mem_ack) begin
                    ir_d    = bus_in;
                    pc_d    = pc_inc(pc);
                    state_d = ST_DECODE;
                end
            end

            ST_DECODE: begin
                case (dec_class)
                    CLS_LDA, CLS_STA, CLS_ALU: state_d = ST_MEM;
                    CLS_JMP: begin
                        pc_d    = operand;
                        state_d = DONE_STATE;
                    end
                    CLS_JZ: begin
                        // acc_value is sampled in this cycle only.
                        if (acc_value == 8'h00) begin
                            pc_d = operand;
                        end
                        state_d = DONE_STATE;
                    end
                    CLS_HLT: state_d = ST_HALT;
                    default: state_d = DONE_STATE;
                endcase
            end

            ST_MEM: begin
                if (mem_ack) begin
                    state_d = DONE_STATE;
                end
            end

            ST_HALT: state_d = ST_HALT;

            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the reset is asynchronous, so it sits in the sensitivity list and
    // takes effect without waiting for a clock edge; all state registers use
    // non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= 4'd0;
            ir    <= 8'h00;
        end else begin
            state <= state_d;
            pc    <= pc_d;
            ir    <= ir_d;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode. Everything is a function of state, ir and mem_ack, so a
    // reset that forces state to IDLE clears every strobe in the same cycle,
    // aborting any access in flight.
    // -------------------------------------------------------------------------
    logic is_sta;

    assign is_sta = (dec_class == CLS_STA);

    always_comb begin
        mem_req       = 1'b0;
        mem_we        = 1'b0;
        mem_addr      = 4'd0;
        acc_sel       = 1'b0;
        acc_write_en  = 1'b0;
        acc_output_en = 1'b0;
        alu_op        = ALU_ADD;
        halted        = 1'b0;

        case (state)
            ST_FETCH: begin
                mem_req  = 1'b1;
                mem_addr = pc;
            end

            ST_MEM: begin
                mem_req       = 1'b1;
                mem_addr      = operand;
                mem_we        = is_sta;
                acc_output_en = is_sta;
                alu_op        = dec_alu_op;
                acc_sel       = dec_acc_sel;
                // Load strobe only in the ack cycle, when the operand (LDA)
                // or the ALU result built from it is valid.
                acc_write_en  = mem_ack & ~is_sta;
            end

            ST_HALT: halted = 1'b1;

            default: ;
        endcase
    end

endmodule

// File: tb/tb_acc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acc_sequencer
//
// Self-checking bench for acc_sequencer. A behavioural memory with a
// programmable number of wait states answers the handshake; a table of
// instruction records walks a program through every instruction class, and
// hand-written sequences cover HALT, reset in the middle of an access and,
// when ACC_SEQ_STEP_EN is defined, single-step operation.
// -----------------------------------------------------------------------------
module tb_acc_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       step = 1'b0;
    logic       mem_req;
    logic       mem_we;
    logic [3:0] mem_addr;
    logic       mem_ack = 1'b0;
    logic [7:0] bus_in = 8'h00;
    logic [7:0] acc_value = 8'h00;
    logic       acc_sel;
    logic       acc_write_en;
    logic       acc_output_en;
    logic [2:0] alu_op;
    logic [3:0] pc;
    logic       halted;

    int errors = 0;
    int checks = 0;

    logic [7:0] mem [16];
    int         waits = 0;

    acc_sequencer dut (
        .clk           (clk),
        .rst           (rst),
`ifdef ACC_SEQ_STEP_EN
        .step          (step),
`endif
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .bus_in        (bus_in),
        .acc_value     (acc_value),
        .acc_sel       (acc_sel),
        .acc_write_en  (acc_write_en),
        .acc_output_en (acc_output_en),
        .alu_op        (alu_op),
        .pc            (pc),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    // Memory model: updates 1 time unit after each rising edge. A request is
    // acknowledged after 'waits' idle cycles; read data is presented in the
    // ack cycle.
    initial begin
        int wcnt;
        logic prev_ack;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            prev_ack = mem_ack;
            if (rst || !mem_req || prev_ack) wcnt = 0;
            mem_ack = 1'b0;
            if (!rst && mem_req) begin
                if (wcnt >= waits) begin
                    mem_ack = 1'b1;
                    bus_in  = mem[mem_addr];
                end else begin
                    wcnt++;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Assert reset for two cycles and release it on a falling edge. Returns on
    // the next falling edge, where the first FETCH must be visible.
    task automatic reset_and_release();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mem_req", mem_req, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_pc", pc, 4'd0);
        check("rst_strobes", {mem_we, acc_write_en, acc_output_en, acc_sel, halted}, 5'd0);
        check("rst_addr_alu", {mem_addr, alu_op}, 7'd0);
        rst = 1'b0;
        #1;
        check("idle_no_req", mem_req, 1'b0);
        @(negedge clk);
    endtask

`ifndef ACC_SEQ_STEP_EN
    typedef struct {
        logic [3:0] addr;       // expected fetch address
        logic [7:0] instr;      // instruction stored there (for operand)
        logic [7:0] acc;        // acc_value presented during the instruction
        int         mem_waits;  // wait states from the MEM cycle onward
        bit         has_mem;    // instruction has a MEM cycle
        bit         exp_we;     // STA: write + acc_output_en
        logic [2:0] exp_alu;
        bit         exp_sel;
        int         exp_writes; // acc_write_en pulses in MEM
        logic [3:0] exp_next;   // next fetch address
    } vec_t;

    vec_t vecs[13];

    // Entered on a falling edge where FETCH of v.addr is showing; returns on
    // the falling edge where the following FETCH is showing.
    task automatic run_vec(input int idx, input vec_t v);
        int         n;
        int         writes;
        logic [3:0] pc_after;
        pc_after  = v.addr + 4'd1;
        acc_value = v.acc;
        check($sformatf("v%0d_fetch_req", idx), {mem_req, mem_we}, 2'b10);
        check($sformatf("v%0d_fetch_addr", idx), mem_addr, v.addr);
        n = 0;
        while (!mem_ack && n < 40) begin
            @(negedge clk);
            n++;
            check($sformatf("v%0d_fetch_hold", idx), {mem_req, mem_addr}, {1'b1, v.addr});
        end
        check($sformatf("v%0d_fetch_ack", idx), mem_ack, 1'b1);
        check($sformatf("v%0d_fetch_nowr", idx), acc_write_en, 1'b0);
        @(negedge clk);
        check($sformatf("v%0d_dec_idle", idx), {mem_req, acc_write_en, acc_output_en}, 3'd0);
        check($sformatf("v%0d_dec_pc", idx), pc, pc_after);
        waits = v.mem_waits;
        if (v.has_mem) begin
            @(negedge clk);
            writes = 0;
            n = 0;
            forever begin
                check($sformatf("v%0d_mem_req_addr", idx), {mem_req, mem_addr}, {1'b1, v.instr[3:0]});
                check($sformatf("v%0d_mem_we_oe", idx), {mem_we, acc_output_en}, {v.exp_we, v.exp_we});
                check($sformatf("v%0d_mem_alu_sel", idx), {alu_op, acc_sel}, {v.exp_alu, v.exp_sel});
                check($sformatf("v%0d_wr_on_ack_only", idx), acc_write_en, mem_ack && !v.exp_we);
                if (acc_write_en) writes++;
                if (mem_ack || n >= 40) break;
                @(negedge clk);
                n++;
            end
            check($sformatf("v%0d_mem_ack", idx), mem_ack, 1'b1);
            check($sformatf("v%0d_writes", idx), writes, v.exp_writes);
        end
        @(negedge clk);
        check($sformatf("v%0d_next_fetch", idx), {mem_req, mem_we, mem_addr}, {2'b10, v.exp_next});
    endtask
`endif

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 8'h00;

`ifdef ACC_SEQ_STEP_EN
        // ---------------- single-step mode ----------------
        mem[0]  = 8'h1A;  // LDA 10
        mem[1]  = 8'h3B;  // would be ADD 11 if a second step came
        mem[10] = 8'h05;
        waits   = 0;
        step    = 1'b0;
        reset_and_release();
        begin
            int seen;
            int writes;
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (mem_req) seen++;
                @(negedge clk);
            end
            check("step_no_fetch", seen, 0);
            step = 1'b1;
            @(negedge clk);
            step = 1'b0;
            check("step_fetch", {mem_req, mem_addr}, {1'b1, 4'd0});
            waits = 2;
            @(negedge clk);  // DECODE (fetch acked with zero waits)
            check("step_dec_pc", pc, 4'd1);
            writes = 0;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                if (acc_write_en) writes++;
            end
            check("step_one_write", writes, 1);
            seen = 0;
            for (int i = 0; i < 10; i++) begin
                if (mem_req) seen++;
                @(negedge clk);
            end
            check("step_parked_idle", seen, 0);
            check("step_pc", pc, 4'd1);
        end
`else
        // ---------------- free-running program ----------------
        mem[0]  = 8'h1A;  // LDA 10
        mem[1]  = 8'h3B;  // ADD 11
        mem[2]  = 8'h2C;  // STA 12
        mem[3]  = 8'h97;  // JZ 7 (acc = 0 -> taken)
        mem[7]  = 8'h95;  // JZ 5 (acc = 1 -> not taken)
        mem[8]  = 8'h4D;  // SUB 13
        mem[9]  = 8'h5D;  // AND 13
        mem[10] = 8'h05;  // NOP (also data for LDA)
        mem[11] = 8'h6E;  // OR 14
        mem[12] = 8'h7E;  // XOR 14
        mem[13] = 8'hA3;  // unassigned -> NOP
        mem[14] = 8'h8F;  // JMP 15
        mem[15] = 8'h00;  // NOP, pc wraps to 0

        //             addr   instr  acc    w  mem we alu     sel wr next
        vecs[0]  = '{4'h0, 8'h1A, 8'h00, 2, 1, 0, 3'b000, 0, 1, 4'h1};
        vecs[1]  = '{4'h1, 8'h3B, 8'h00, 1, 1, 0, 3'b000, 1, 1, 4'h2};
        vecs[2]  = '{4'h2, 8'h2C, 8'h00, 0, 1, 1, 3'b000, 0, 0, 4'h3};
        vecs[3]  = '{4'h3, 8'h97, 8'h00, 0, 0, 0, 3'b000, 0, 0, 4'h7};
        vecs[4]  = '{4'h7, 8'h95, 8'h01, 0, 0, 0, 3'b000, 0, 0, 4'h8};
        vecs[5]  = '{4'h8, 8'h4D, 8'h01, 1, 1, 0, 3'b001, 1, 1, 4'h9};
        vecs[6]  = '{4'h9, 8'h5D, 8'h01, 0, 1, 0, 3'b010, 1, 1, 4'hA};
        vecs[7]  = '{4'hA, 8'h05, 8'h01, 0, 0, 0, 3'b000, 0, 0, 4'hB};
        vecs[8]  = '{4'hB, 8'h6E, 8'h01, 3, 1, 0, 3'b011, 1, 1, 4'hC};
        vecs[9]  = '{4'hC, 8'h7E, 8'h01, 0, 1, 0, 3'b100, 1, 1, 4'hD};
        vecs[10] = '{4'hD, 8'hA3, 8'h01, 0, 0, 0, 3'b000, 0, 0, 4'hE};
        vecs[11] = '{4'hE, 8'h8F, 8'h01, 0, 0, 0, 3'b000, 0, 0, 4'hF};
        vecs[12] = '{4'hF, 8'h00, 8'h01, 0, 0, 0, 3'b000, 0, 0, 4'h0};

        waits = 0;
        reset_and_release();
        check("first_fetch", {mem_req, mem_addr}, {1'b1, 4'd0});
        for (int i = 0; i < 13; i++) run_vec(i, vecs[i]);

        // ---------------- reset in the middle of a MEM cycle ----------------
        waits = 3;
        reset_and_release();
        begin
            int n;
            int writes;
            n = 0;
            while (!(mem_req && mem_addr == 4'd10 && pc == 4'd1) && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("abort_in_mem", {mem_req, mem_addr, mem_ack}, {1'b1, 4'd10, 1'b0});
            #2;
            rst = 1'b1;
            #1;
            check("abort_req_drop", {mem_req, acc_write_en, acc_sel}, 3'd0);
            check("abort_pc", pc, 4'd0);
            writes = 0;
            for (int i = 0; i < 4; i++) begin
                @(negedge clk);
                if (acc_write_en || mem_req) writes++;
            end
            check("abort_quiet", writes, 0);
            rst = 1'b0;
            #1;
            check("abort_idle", mem_req, 1'b0);
            @(negedge clk);
            check("abort_refetch", {mem_req, mem_addr}, {1'b1, 4'd0});
        end

        // ---------------- HALT ----------------
        mem[0] = 8'hF0;
        waits  = 0;
        reset_and_release();
        begin
            int reqs;
            int halt_cycles;
            check("hlt_fetch", {mem_req, mem_addr}, {1'b1, 4'd0});
            @(negedge clk);
            check("hlt_decode", {halted, mem_req}, 2'b00);
            @(negedge clk);
            reqs = 0;
            halt_cycles = 0;
            for (int i = 0; i < 20; i++) begin
                if (mem_req) reqs++;
                if (halted) halt_cycles++;
                @(negedge clk);
            end
            check("hlt_no_req", reqs, 0);
            check("hlt_halted", halt_cycles, 20);
            check("hlt_pc", pc, 4'd1);
            check("hlt_strobes", {acc_write_en, acc_output_en, mem_we}, 3'd0);
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Absolute time limit so a stuck run still ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/acc_sequencer.md
ACC_SEQUENCER -- requirements
Module: acc_sequencer

Interface
REQ-001 SHALL have exactly one clock and one reset; reset is asynchronous and active-high.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous active-high reset.
REQ-004 mem_req  output  1  memory access request, held until acknowledged.
REQ-005 mem_we  output  1  1 = write (STA), 0 = read; valid while mem_req=1.
REQ-006 mem_addr  output  4  access address; valid while mem_req=1.
REQ-007 mem_ack  input  1  memory completion strobe, one cycle; read data valid on bus_in in that cycle.
REQ-008 bus_in  input  8  shared data bus carrying instruction and operand read data.
REQ-009 acc_value  input  8  current accumulator contents, used for the JZ zero test.
REQ-010 acc_sel  output  1  accumulator source select: 1 = ALU result, 0 = bus.
REQ-011 acc_write_en  output  1  accumulator load strobe.
REQ-012 acc_output_en  output  1  accumulator drives the bus.
REQ-013 alu_op  output  3  ALU operation: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR.
REQ-014 pc  output  4  program counter.
REQ-015 halted  output  1  high while in HALT.

Function
REQ-016 Instruction format SHALL be ir[7:4] opcode and ir[3:0] operand.
REQ-017 Opcodes: 0 NOP, 1 LDA, 2 STA, 3 ADD, 4 SUB, 5 AND, 6 OR, 7 XOR, 8 JMP, 9 JZ, F HLT. Opcodes A-E SHALL execute as NOP.
REQ-018 States SHALL be IDLE, FETCH, DECODE, MEM and HALT; all outputs decode from state, ir and mem_ack.
REQ-019 IDLE: all strobes 0; moves to FETCH on the next cycle.
REQ-020 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack, ir<=bus_in, pc<=pc+1 mod 16, move to DECODE.
REQ-021 DECODE takes one cycle with all strobes 0:
- LDA, STA, ADD-XOR: move to MEM.
- JMP: pc<=operand, then FETCH.
- JZ: pc<=operand only if acc_value==0 (sampled this cycle), then FETCH.
- NOP and A-E: FETCH.
- HLT: HALT.
REQ-022 MEM: mem_req=1, mem_addr=operand.
- STA: mem_we=1, acc_output_en=1.
- Other opcodes: mem_we=0, acc_output_en=0.
- alu_op = opcode-3 for ADD-XOR; otherwise 000.
REQ-023 In the MEM cycle with mem_ack=1 and opcode not STA: acc_write_en=1, with acc_sel=1 for ADD-XOR and 0 for LDA. acc_write_en SHALL be 0 in every other cycle.
REQ-024 MEM SHALL move to FETCH on mem_ack; mem_ack while mem_req=0 SHALL be ignored.
REQ-025 Wait states SHALL be unbounded: FETCH and MEM hold all outputs stable until mem_ack.
REQ-026 HALT: halted=1, all strobes 0; left only by reset.
REQ-027 pc SHALL wrap 15->0 without a flag.

Reset
REQ-028 rst SHALL immediately force: state IDLE, pc 0, ir 0; mem_req, mem_we, acc_write_en, acc_output_en, acc_sel, halted 0; mem_addr 0; alu_op 000.
REQ-029 Reset mid-access SHALL abort the transfer with no accumulator write; the first fetch after release is from address 0, one cycle after rst deasserts.

Configuration
REQ-030 Macro ACC_SEQ_STEP_EN SHALL add input step (1 bit).
- Defined: IDLE moves to FETCH only when step=1, and every completed instruction returns to IDLE instead of FETCH.
- Undefined: the step port is absent and behaviour is as REQ-019..REQ-024.

Structure
REQ-031 Package acc_seq_pkg SHALL hold the opcode constants, the state enum and the alu_op constants.
REQ-032 Sub-module acc_seq_decode (combinational: opcode -> class, alu_op, acc_sel) SHALL be the only sub-module.

Verification
REQ-033 Reset and fetch: release rst, memory acks after 0 wait states -> mem_req=1 with mem_addr=0 one cycle after release.
REQ-034 LDA: mem[0]=0x1A, mem[10]=0x05, ack after 2 wait states.
- Expected: MEM cycle with mem_addr=10; acc_write_en=1 and acc_sel=0 only in the ack cycle; pc=1.
REQ-035 ADD: mem[1]=0x3B -> in MEM, alu_op=000 and acc_sel=1; single acc_write_en pulse.
REQ-036 STA and JZ:
- STA: mem[2]=0x2C -> mem_we=1, acc_output_en=1, mem_addr=12, no acc_write_en.
- JZ 0x97 with acc_value=0 -> next fetch from 7.
- JZ 0x97 with acc_value=0x01 -> next fetch from pc.
REQ-037 Wrap, HALT and reset:
- JMP 0x8F then NOP at 15 -> next fetch from 0.
- HLT -> halted=1, no mem_req for 20 cycles.
- rst asserted mid-MEM -> mem_req drops in the same cycle, no write.
REQ-038 ACC_SEQ_STEP_EN defined: no fetch without step; one step pulse executes exactly one LDA, then the block sits in IDLE.
